// File: rtl/ddr2_fifo_pkg.sv
// rtl/ddr2_fifo_pkg.sv - shared DDR2 data-path widths, state type and ratio helpers
package ddr2_fifo_pkg;

  localparam int DDR2_DI_WIDTH = 64;
  localparam int DDR2_DO_WIDTH = 32;

  typedef enum logic {
    DFO_IDLE  = 1'b0,
    DFO_SHIFT = 1'b1
  } dfo_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int ratio_of(input int wide_w, input int narrow_w);
    return wide_w / narrow_w;
  endfunction

  // Shared with the write-path packer: wide word must split evenly into >= 2 slices.
  function automatic bit ratio_legal(input int wide_w, input int narrow_w);
    return (narrow_w > 0) && (wide_w % narrow_w == 0) && (wide_w / narrow_w >= 2);
  endfunction

endpackage

// File: rtl/data_format_out.sv
// rtl/data_format_out.sv - DDR2 read-path width down-converter, MSB slice first
module data_format_out
  import ddr2_fifo_pkg::*;
#(
  parameter int  DI_WIDTH = DDR2_DI_WIDTH,
  parameter int  DO_WIDTH = DDR2_DO_WIDTH,
  localparam int RATIO    = ratio_of(DI_WIDTH, DO_WIDTH),
  localparam int CNT_W    = clog2(RATIO + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DI_WIDTH-1:0] din,
  input  logic [CNT_W-1:0]    din_cnt,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [DO_WIDTH-1:0] dout,
  output logic                dout_vd,
  input  logic                dout_ready,
  output logic                busy
);

  generate
    if (!ratio_legal(DI_WIDTH, DO_WIDTH)) begin : g_illegal_ratio
      $error("data_format_out: DI_WIDTH must be a multiple of DO_WIDTH with ratio >= 2");
    end
  endgenerate

  dfo_state_t          state;
  logic [DI_WIDTH-1:0] buffer;
  logic [CNT_W-1:0]    remaining;
  logic [CNT_W-1:0]    n_eff;
  logic [DI_WIDTH-1:0] load_buf;
  logic                accept;
  logic                consume;

  // Out-of-range counts mean a full word; left-justify so the first valid slice is on top.
  always_comb begin
    n_eff    = din_cnt;
    load_buf = '0;
    if (din_cnt == '0 || din_cnt > CNT_W'(RATIO)) begin
      n_eff = CNT_W'(RATIO);
    end
    load_buf = din << (DO_WIDTH * (RATIO - int'(n_eff)));
  end

  assign din_ready = !reset && ((state == DFO_IDLE) ||
                                (remaining == CNT_W'(1) && dout_ready));
  assign accept    = din_valid && din_ready;
  assign consume   = dout_vd && dout_ready;
  assign busy      = dout_vd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DFO_IDLE;
      buffer    <= '0;
      remaining <= '0;
      dout      <= '0;
      dout_vd   <= 1'b0;
    end else if (accept) begin
      buffer    <= load_buf;
      dout      <= load_buf[DI_WIDTH-1 -: DO_WIDTH];
      remaining <= n_eff;
      dout_vd   <= 1'b1;
      state     <= DFO_SHIFT;
    end else if (consume) begin
      if (remaining > CNT_W'(1)) begin
        buffer    <= buffer << DO_WIDTH;
        dout      <= buffer[DI_WIDTH-DO_WIDTH-1 -: DO_WIDTH];
        remaining <= remaining - CNT_W'(1);
      end else begin
        remaining <= '0;
        dout_vd   <= 1'b0;
        state     <= DFO_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_data_format_out.sv
// tb/tb_data_format_out.sv - directed and scoreboard checks for data_format_out
module tb_data_format_out;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // RATIO=2 instance
  logic [63:0]  a_din;
  logic [1:0]   a_din_cnt;
  logic         a_din_valid, a_din_ready;
  logic [31:0]  a_dout;
  logic         a_dout_vd, a_dout_ready, a_busy;

  // RATIO=4 instance
  logic [127:0] b_din;
  logic [2:0]   b_din_cnt;
  logic         b_din_valid, b_din_ready;
  logic [31:0]  b_dout;
  logic         b_dout_vd, b_dout_ready, b_busy;

  data_format_out #(.DI_WIDTH(64), .DO_WIDTH(32)) u_dut_a (
    .clk(clk), .reset(reset),
    .din(a_din), .din_cnt(a_din_cnt), .din_valid(a_din_valid), .din_ready(a_din_ready),
    .dout(a_dout), .dout_vd(a_dout_vd), .dout_ready(a_dout_ready), .busy(a_busy)
  );

  data_format_out #(.DI_WIDTH(128), .DO_WIDTH(32)) u_dut_b (
    .clk(clk), .reset(reset),
    .din(b_din), .din_cnt(b_din_cnt), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .dout(b_dout), .dout_vd(b_dout_vd), .dout_ready(b_dout_ready), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_a[$], obs_a[$], exp_b[$], obs_b[$];

  // Scoreboard: expand every accepted word MSB-first, record every consumed slice.
  always @(posedge clk) begin
    if (!reset) begin
      if (a_din_valid && a_din_ready) begin
        int n;
        n = (a_din_cnt == 0 || a_din_cnt > 2) ? 2 : int'(a_din_cnt);
        for (int j = n - 1; j >= 0; j--) exp_a.push_back(a_din[j*32 +: 32]);
      end
      if (a_dout_vd && a_dout_ready) obs_a.push_back(a_dout);
      if (b_din_valid && b_din_ready) begin
        int n;
        n = (b_din_cnt == 0 || b_din_cnt > 4) ? 4 : int'(b_din_cnt);
        for (int j = n - 1; j >= 0; j--) exp_b.push_back(b_din[j*32 +: 32]);
      end
      if (b_dout_vd && b_dout_ready) obs_b.push_back(b_dout);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sb_clear();
    exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
  endtask

  task automatic sb_check(input string tag);
    check({tag, "_a_count"}, obs_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++)
      if (obs_a[i] !== exp_a[i]) check({tag, "_a_slice"}, obs_a[i], exp_a[i]);
    check({tag, "_b_count"}, obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++)
      if (obs_b[i] !== exp_b[i]) check({tag, "_b_slice"}, obs_b[i], exp_b[i]);
    sb_clear();
  endtask

  logic [63:0] words[8];

  initial begin
    int vd_cycles, vd_rises, idx;
    logic prev_vd, will_accept;

    reset = 1'b1;
    a_din = '0; a_din_cnt = '0; a_din_valid = 1'b0; a_dout_ready = 1'b1;
    b_din = '0; b_din_cnt = '0; b_din_valid = 1'b0; b_dout_ready = 1'b1;
    @(negedge clk);
    check("rst_din_ready", a_din_ready, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("rst_dout", a_dout, 32'h0);
    check("rst_dout_vd", a_dout_vd, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_idle_ready", a_din_ready, 1'b1);
    @(negedge clk);

    // Full word, ready tied high
    a_din = 64'h1111_1111_2222_2222; a_din_cnt = 2'd2; a_din_valid = 1'b1;
    step();
    a_din_valid = 1'b0;
    check("full_s0", a_dout, 32'h1111_1111);
    check("full_s0_vd", a_dout_vd, 1'b1);
    check("full_s0_rdy", a_din_ready, 1'b0);
    step();
    check("full_s1", a_dout, 32'h2222_2222);
    check("full_s1_rdy", a_din_ready, 1'b1);
    step();
    check("full_end_vd", a_dout_vd, 1'b0);
    check("full_end_dout_hold", a_dout, 32'h2222_2222);

    // Partial word then out-of-range count
    a_din = 64'h0000_0000_AAAA_AAAA; a_din_cnt = 2'd1; a_din_valid = 1'b1;
    step();
    a_din_valid = 1'b0;
    check("part_s0", a_dout, 32'hAAAA_AAAA);
    check("part_s0_vd", a_dout_vd, 1'b1);
    step();
    check("part_end_vd", a_dout_vd, 1'b0);
    a_din = 64'h3333_3333_4444_4444; a_din_cnt = 2'd0; a_din_valid = 1'b1;
    step();
    a_din_valid = 1'b0;
    check("cnt0_s0", a_dout, 32'h3333_3333);
    step();
    check("cnt0_s1", a_dout, 32'h4444_4444);
    step();
    check("cnt0_end_vd", a_dout_vd, 1'b0);
    sb_check("directed");

    // Back-to-back streaming of 8 full words
    for (int i = 0; i < 8; i++) words[i] = {8'(i + 1), 24'hA0_0000 + 24'(i), 8'(i + 8'h80), 24'hB0_0000 + 24'(i)};
    idx = 0; vd_cycles = 0; vd_rises = 0; prev_vd = 1'b0;
    a_din_cnt = 2'd2;
    for (int c = 0; c < 22; c++) begin
      if (idx < 8) begin a_din = words[idx]; a_din_valid = 1'b1; end
      else a_din_valid = 1'b0;
      will_accept = a_din_valid && a_din_ready;
      step();
      if (will_accept) idx++;
      if (a_dout_vd) vd_cycles++;
      if (a_dout_vd && !prev_vd) vd_rises++;
      prev_vd = a_dout_vd;
    end
    check("stream_words", idx, 8);
    check("stream_vd_cycles", vd_cycles, 16);
    check("stream_no_bubble", vd_rises, 1);
    sb_check("stream");

    // Backpressure with a second word waiting
    a_dout_ready = 1'b0;
    a_din = 64'h1111_1111_2222_2222; a_din_cnt = 2'd2; a_din_valid = 1'b1;
    step();
    a_din = 64'h5555_5555_6666_6666;
    for (int c = 0; c < 5; c++) begin
      check("bp_dout", a_dout, 32'h1111_1111);
      check("bp_vd", a_dout_vd, 1'b1);
      check("bp_din_ready", a_din_ready, 1'b0);
      step();
    end
    a_dout_ready = 1'b1;
    #1;
    check("bp_rel_ready", a_din_ready, 1'b0);
    step();
    check("bp_s1", a_dout, 32'h2222_2222);
    check("bp_s1_rdy", a_din_ready, 1'b1);
    step();
    a_din_valid = 1'b0;
    check("bp_w2_s0", a_dout, 32'h5555_5555);
    step();
    check("bp_w2_s1", a_dout, 32'h6666_6666);
    step();
    check("bp_end_vd", a_dout_vd, 1'b0);
    sb_check("backpressure");

    // Reset while holding slice 1 of 2
    a_dout_ready = 1'b0;
    a_din = 64'h7777_7777_8888_8888; a_din_cnt = 2'd2; a_din_valid = 1'b1;
    step();
    a_din_valid = 1'b0;
    check("rstmid_s0", a_dout, 32'h7777_7777);
    reset = 1'b1;
    step();
    check("rstmid_hold_rdy", a_din_ready, 1'b0);
    reset = 1'b0;
    a_dout_ready = 1'b1;
    #1;
    check("rstmid_vd", a_dout_vd, 1'b0);
    check("rstmid_dout", a_dout, 32'h0);
    check("rstmid_rdy", a_din_ready, 1'b1);
    @(negedge clk);
    step();
    check("rstmid_no_s1", a_dout_vd, 1'b0);
    sb_clear();

    // Random valid/ready on both instances
    for (int c = 0; c < 400; c++) begin
      a_din_valid  = ($urandom_range(0, 3) != 0);
      a_dout_ready = ($urandom_range(0, 3) != 0);
      a_din        = {$urandom, $urandom};
      a_din_cnt    = 2'($urandom_range(0, 3));
      b_din_valid  = ($urandom_range(0, 2) != 0);
      b_dout_ready = ($urandom_range(0, 2) != 0);
      b_din        = {$urandom, $urandom, $urandom, $urandom};
      b_din_cnt    = 3'($urandom_range(0, 7));
      step();
    end
    a_din_valid = 1'b0; b_din_valid = 1'b0;
    a_dout_ready = 1'b1; b_dout_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    check("rand_a_idle", a_dout_vd, 1'b0);
    check("rand_b_idle", b_dout_vd, 1'b0);
    sb_check("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
